// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// Contents: FSM state enum, 4-bit opcode constants, 2-bit ALU op constants.
package ctrl_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned ALUOP_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    HALTED
  } state_t;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ANDI = 4'b0101;
  localparam logic [OPC_W-1:0] OP_ORI  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_LD   = 4'b0111;
  localparam logic [OPC_W-1:0] OP_ST   = 4'b1000;
  localparam logic [OPC_W-1:0] OP_BEQ  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_HALT = 4'b1111;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the control unit and instruction/data memory.
// master (controller): drives mem_req, mem_we, mem_addr_sel; receives mem_ready, mem_rdata.
// slave (memory): the reverse.
interface multicycle_controller_if #(
  parameter int unsigned DATA_W = 18
);
  logic              mem_req;
  logic              mem_we;
  logic              mem_addr_sel;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr_sel,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr_sel,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter: holds pc and selects increment, branch target or jump target.
// Ports: clk, rst (async high), inc/branch/jump strobes, offset (extended imm),
//        target (jump address), pc (current program counter).
module pc_unit #(
  parameter int unsigned      DATA_W   = 18,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              branch,
  input  logic              jump,
  input  logic [DATA_W-1:0] offset,
  input  logic [DATA_W-1:0] target,
  output logic [DATA_W-1:0] pc
);

  // Strobes are mutually exclusive by FSM construction; all adds wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (inc) begin
      pc <= pc + DATA_W'(1);
    end else if (branch) begin
      pc <= pc + offset;
    end else if (jump) begin
      pc <= target;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: fetches instructions, holds IR, extends the immediate
// and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for the 18-bit datapath.
// Ports: clk, rst (async high), mem (memory handshake interface, master side),
//        run, alu_zero, rs_data in; pc, ir, imm_ext, alu_op, alu_src_imm,
//        rf_we, rf_wsel, mdr_we, halted, illegal out.
// Build option: CTRL_ZERO_EXT_EN makes ANDI/ORI zero-extend their immediate.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W   = 18,
  parameter int unsigned       IMM_W    = 6,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  mem,
  input  logic                     run,
  input  logic                     alu_zero,
  input  logic [DATA_W-1:0]        rs_data,
  output logic [DATA_W-1:0]        pc,
  output logic [DATA_W-1:0]        ir,
  output logic [DATA_W-1:0]        imm_ext,
  output logic [ALUOP_W-1:0]       alu_op,
  output logic                     alu_src_imm,
  output logic                     rf_we,
  output logic                     rf_wsel,
  output logic                     mdr_we,
  output logic                     halted,
  output logic                     illegal
);

  state_t           state;
  logic [OPC_W-1:0] opc;
  logic             imm_fill_c;
  logic             pc_inc_c;
  logic             pc_branch_c;
  logic             pc_jump_c;

  assign opc = ir[DATA_W-1 -: OPC_W];

  // Fill bit for the immediate of the word being fetched.
  always_comb begin
    imm_fill_c = mem.mem_rdata[IMM_W-1];
`ifdef CTRL_ZERO_EXT_EN
    if (mem.mem_rdata[DATA_W-1 -: OPC_W] inside {OP_ANDI, OP_ORI}) begin
      imm_fill_c = 1'b0;
    end
`endif
  end

  // State register, IR and extended immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ir      <= '0;
      imm_ext <= '0;
    end else begin
      case (state)
        IDLE:      if (run) state <= FETCH;
        FETCH: begin
          if (mem.mem_ready) begin
            ir      <= mem.mem_rdata;
            imm_ext <= {{(DATA_W-IMM_W){imm_fill_c}}, mem.mem_rdata[IMM_W-1:0]};
            state   <= DECODE;
          end
        end
        DECODE:    state <= EXECUTE;
        EXECUTE: begin
          case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI: state <= WRITEBACK;
            OP_LD, OP_ST:             state <= MEM;
            OP_HALT:                  state <= HALTED;
            default:                  state <= FETCH;
          endcase
        end
        MEM: begin
          if (mem.mem_ready) state <= (opc == OP_LD) ? WRITEBACK : FETCH;
        end
        WRITEBACK: state <= FETCH;
        HALTED:    state <= HALTED;
        default:   state <= IDLE;
      endcase
    end
  end

  // Control outputs and pc strobes decoded from state and IR.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    alu_op           = ALU_ADD;
    alu_src_imm      = 1'b0;
    rf_we            = 1'b0;
    rf_wsel          = 1'b0;
    mdr_we           = 1'b0;
    halted           = 1'b0;
    illegal          = 1'b0;
    pc_inc_c         = 1'b0;
    pc_branch_c      = 1'b0;
    pc_jump_c        = 1'b0;
    case (state)
      FETCH: begin
        mem.mem_req = 1'b1;
        pc_inc_c    = mem.mem_ready;
      end
      EXECUTE: begin
        case (opc)
          OP_SUB, OP_BEQ:  alu_op = ALU_SUB;
          OP_AND, OP_ANDI: alu_op = ALU_AND;
          OP_OR, OP_ORI:   alu_op = ALU_OR;
          default:         alu_op = ALU_ADD;
        endcase
        alu_src_imm = opc inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_ST};
        illegal     = !(opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
                                    OP_ORI, OP_LD, OP_ST, OP_BEQ, OP_JMP, OP_HALT});
        pc_branch_c = (opc == OP_BEQ) && alu_zero;
        pc_jump_c   = (opc == OP_JMP);
      end
      MEM: begin
        // Address add is held for the whole access.
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = (opc == OP_ST);
        alu_op           = ALU_ADD;
        alu_src_imm      = 1'b1;
        mdr_we           = (opc == OP_LD) && mem.mem_ready;
      end
      WRITEBACK: begin
        rf_we   = 1'b1;
        rf_wsel = (opc == OP_LD);
      end
      HALTED:  halted = 1'b1;
      default: ;
    endcase
  end

  pc_unit #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .inc    (pc_inc_c),
    .branch (pc_branch_c),
    .jump   (pc_jump_c),
    .offset (imm_ext),
    .target (rs_data),
    .pc     (pc)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  localparam int unsigned DW = 18;

  // Control vector: {mem_req, mem_we, mem_addr_sel, alu_op[1:0], alu_src_imm,
  //                  rf_we, rf_wsel, mdr_we, halted, illegal}
  localparam logic [10:0] C_REQ  = 11'h400;
  localparam logic [10:0] C_WE   = 11'h200;
  localparam logic [10:0] C_ASEL = 11'h100;
  localparam logic [10:0] C_AND  = 11'h080;
  localparam logic [10:0] C_SUB  = 11'h040;
  localparam logic [10:0] C_OR   = 11'h0C0;
  localparam logic [10:0] C_IMM  = 11'h020;
  localparam logic [10:0] C_RFWE = 11'h010;
  localparam logic [10:0] C_WSEL = 11'h008;
  localparam logic [10:0] C_MDR  = 11'h004;
  localparam logic [10:0] C_HALT = 11'h002;
  localparam logic [10:0] C_ILL  = 11'h001;
  localparam logic [10:0] C_NONE = 11'h000;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          alu_zero;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] pc, ir, imm_ext;
  logic [1:0]    alu_op;
  logic          alu_src_imm, rf_we, rf_wsel, mdr_we, halted, illegal;
  logic [10:0]   ctl;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_controller_if #(.DATA_W(DW)) mif ();

  multicycle_controller #(.DATA_W(DW), .IMM_W(6), .RESET_PC('0)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (mif),
    .run         (run),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .pc          (pc),
    .ir          (ir),
    .imm_ext     (imm_ext),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .mdr_we      (mdr_we),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign ctl = {mif.mem_req, mif.mem_we, mif.mem_addr_sel, alu_op, alu_src_imm,
                rf_we, rf_wsel, mdr_we, halted, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_ctl(input string tag, input logic [10:0] e);
    check(tag, 32'(ctl), 32'(e));
  endtask

  // Called at a negedge in FETCH; hands over the instruction with no wait and
  // returns at the DECODE negedge.
  task automatic issue(input string tag, input logic [DW-1:0] instr);
    check_ctl({tag, "_fetch"}, C_REQ);
    mif.mem_ready = 1'b1;
    mif.mem_rdata = instr;
    tick();
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    check_ctl({tag, "_decode"}, C_NONE);
    check({tag, "_ir"}, 32'(ir), 32'(instr));
  endtask

  initial begin
    logic [DW-1:0] ori_ext;
`ifdef CTRL_ZERO_EXT_EN
    ori_ext = 18'h00020;
`else
    ori_ext = 18'h3FFE0;
`endif
    rst           = 1'b1;
    run           = 1'b0;
    alu_zero      = 1'b0;
    rs_data       = '0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    tick();
    tick();
    check_ctl("reset_ctl", C_NONE);
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_ir", 32'(ir), 32'h0);
    check("reset_imm", 32'(imm_ext), 32'h0);

    rst = 1'b0;
    run = 1'b1;
    #1 check_ctl("idle_ctl", C_NONE);
    tick();
    run = 1'b0;
    check_ctl("first_fetch", C_REQ);

    // ADDI imm=111111 at pc 0
    issue("addi", {4'b0100, 3'd1, 3'd2, 8'h3F});
    check("addi_imm", 32'(imm_ext), 32'h3FFFF);
    check("addi_pc", 32'(pc), 32'd1);
    tick(); check_ctl("addi_exec", C_IMM);
    tick(); check_ctl("addi_wb", C_RFWE);
    tick();

    // ORI imm=100000 at pc 1
    issue("ori", {4'b0110, 3'd1, 3'd1, 8'h20});
    check("ori_imm", 32'(imm_ext), 32'(ori_ext));
    tick(); check_ctl("ori_exec", C_OR | C_IMM);
    tick(); check_ctl("ori_wb", C_RFWE);
    tick();

    // JMP to 5 from pc 2
    rs_data = 18'd5;
    issue("jmp", {4'b1010, 14'd0});
    tick(); check_ctl("jmp_exec", C_NONE);
    tick(); rs_data = '0;
    check("jmp_pc", 32'(pc), 32'd5);

    // BEQ at pc 5, imm -2, taken: 6 - 2 = 4
    issue("beqt", {4'b1001, 6'd0, 8'h3E});
    check("beqt_pc_inc", 32'(pc), 32'd6);
    tick(); alu_zero = 1'b1;
    check_ctl("beqt_exec", C_SUB);
    tick(); alu_zero = 1'b0;
    check("beqt_pc", 32'(pc), 32'd4);
    check_ctl("beqt_fetch", C_REQ);

    // ADD at pc 4
    issue("add", {4'b0000, 3'd3, 3'd1, 2'b00, 3'd2, 3'd0});
    tick(); check_ctl("add_exec", C_NONE);
    tick(); check_ctl("add_wb", C_RFWE);
    tick();

    // BEQ at pc 5, not taken: 6
    issue("beqn", {4'b1001, 6'd0, 8'h3E});
    tick(); check_ctl("beqn_exec", C_SUB);
    tick();
    check("beqn_pc", 32'(pc), 32'd6);

    // LD with 3 memory wait cycles
    issue("ld", {4'b0111, 3'd2, 3'd1, 8'h04});
    tick(); check_ctl("ld_exec", C_IMM);
    for (int i = 0; i < 3; i++) begin
      tick(); check_ctl("ld_wait", C_REQ | C_ASEL | C_IMM);
    end
    tick();
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 18'h2A5A5;
    #1 check_ctl("ld_ready", C_REQ | C_ASEL | C_IMM | C_MDR);
    tick();
    mif.mem_ready = 1'b0;
    check_ctl("ld_wb", C_RFWE | C_WSEL);
    tick();
    check("ld_pc", 32'(pc), 32'd7);

    // ST zero wait
    issue("st", {4'b1000, 3'd0, 3'd1, 2'b00, 3'd2, 3'd1});
    tick(); check_ctl("st_exec", C_IMM);
    tick();
    mif.mem_ready = 1'b1;
    #1 check_ctl("st_mem", C_REQ | C_WE | C_ASEL | C_IMM);
    tick();
    mif.mem_ready = 1'b0;
    check_ctl("st_no_rfwe", C_REQ);
    check("st_pc", 32'(pc), 32'd8);

    // Illegal opcode 1011
    issue("ill", {4'b1011, 14'd0});
    tick(); check_ctl("ill_exec", C_ILL);
    tick(); check_ctl("ill_resume", C_REQ);
    check("ill_pc", 32'(pc), 32'd9);

    // Reset in the middle of a LD memory access
    issue("ldr", {4'b0111, 3'd2, 3'd1, 8'h01});
    tick();
    tick(); check_ctl("ldr_mem", C_REQ | C_ASEL | C_IMM);
    #2 rst = 1'b1;
    #1 check_ctl("rst_mid_mem", C_NONE);
    check("rst_mid_pc", 32'(pc), 32'h0);
    check("rst_mid_ir", 32'(ir), 32'h0);
    tick(); rst = 1'b0;
    tick(); check_ctl("rst_idle", C_NONE);
    run = 1'b1;
    tick(); run = 1'b0;

    // HALT then 20 quiet cycles, memory ready toggling
    issue("halt", {4'b1111, 14'd0});
    tick(); check_ctl("halt_exec", C_NONE);
    for (int i = 0; i < 20; i++) begin
      tick();
      mif.mem_ready = 1'(i & 1);
      check_ctl("halted", C_HALT);
    end
    check("halt_pc", 32'(pc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
